// File: rtl/register_file_pkg.sv
// Shared TinyCPU register-file definitions: default geometry and architectural register names.
package register_file_pkg;

  localparam int TC_WIDTH = 8;
  localparam int TC_DEPTH = 4;

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2,
    R3 = 2'd3
  } tc_reg_e;

endpackage

// File: rtl/register_file_scoreboard.sv
// Per-entry busy bits for hazard detection; a new producer (set) beats a retiring write (clr).
module register_file_scoreboard
  import register_file_pkg::*;
#(
  parameter int DEPTH = TC_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Clr,
  input  logic             set,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] busy_vec
);

  always_ff @(posedge Clock or posedge Clr) begin
    if (Clr) begin
      busy_vec <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (set && set_addr == AW'(i))
          busy_vec[i] <= 1'b1;
        else if (clr && clr_addr == AW'(i))
          busy_vec[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// TinyCPU register file: 1 write port, 2 combinational read ports with optional bypass,
// optional hardwired zero entry, and a busy scoreboard for decode hazard checks.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH   = TC_WIDTH,
  parameter int DEPTH   = TC_DEPTH,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Clr,
  input  logic             Enable,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [AW-1:0]    RdAddrA,
  output logic [WIDTH-1:0] RdDataA,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] RdDataB,
  input  logic             SetBusy,
  input  logic [AW-1:0]    SetBusyAddr,
  output logic             BusyA,
  output logic             BusyB
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_vec;
  logic             wcommit;
  logic             scommit;

  function automatic logic addr_valid(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (R0_ZERO != 0) && (a == AW'(R0));
  endfunction

  // Clr is folded in so a bypassed write cannot leak onto the read ports during reset.
  assign wcommit = ~Clr & Enable & WrEn & addr_valid(WrAddr) & ~is_zero_reg(WrAddr);
  assign scommit = ~Clr & Enable & SetBusy & addr_valid(SetBusyAddr) & ~is_zero_reg(SetBusyAddr);

  always_ff @(posedge Clock or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wcommit) begin
      mem[WrAddr] <= WrData;
    end
  end

  register_file_scoreboard #(
    .DEPTH(DEPTH)
  ) u_scoreboard (
    .Clock   (Clock),
    .Clr     (Clr),
    .set     (scommit),
    .set_addr(SetBusyAddr),
    .clr     (wcommit),
    .clr_addr(WrAddr),
    .busy_vec(busy_vec)
  );

  function automatic logic hit_write(input logic [AW-1:0] a);
    return (BYPASS != 0) && wcommit && (WrAddr == a);
  endfunction

  function automatic logic [WIDTH-1:0] read_data(input logic [AW-1:0] a);
    logic [WIDTH-1:0] d;
    d = '0;
    if (Clr || !addr_valid(a) || is_zero_reg(a))
      d = '0;
    else if (hit_write(a))
      d = WrData;
    else
      d = mem[a];
    return d;
  endfunction

  function automatic logic read_busy(input logic [AW-1:0] a);
    logic b;
    b = 1'b0;
    if (!Clr && addr_valid(a))
      b = busy_vec[a] & ~hit_write(a);
    return b;
  endfunction

  always_comb begin
    RdDataA = read_data(RdAddrA);
    RdDataB = read_data(RdAddrB);
    BusyA   = read_busy(RdAddrA);
    BusyB   = read_busy(RdAddrB);
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: three instances (default, no bypass, R0_ZERO/DEPTH=3)
// share one stimulus stream; expectations are queued and checked by a separate monitor.
module tb_register_file;

  localparam int W  = 8;
  localparam int AW = 2;

  logic          Clock;
  logic          Clr;
  logic          Enable;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [W-1:0]  WrData;
  logic [AW-1:0] RdAddrA;
  logic [AW-1:0] RdAddrB;
  logic          SetBusy;
  logic [AW-1:0] SetBusyAddr;

  logic [W-1:0] m_a, m_b, n_a, n_b, z_a, z_b;
  logic         m_ba, m_bb, n_ba, n_bb, z_ba, z_bb;

  register_file #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .R0_ZERO(0)) u_main (
    .Clock(Clock), .Clr(Clr), .Enable(Enable), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdDataA(m_a), .RdAddrB(RdAddrB), .RdDataB(m_b),
    .SetBusy(SetBusy), .SetBusyAddr(SetBusyAddr), .BusyA(m_ba), .BusyB(m_bb));

  register_file #(.WIDTH(8), .DEPTH(4), .BYPASS(0), .R0_ZERO(0)) u_nobyp (
    .Clock(Clock), .Clr(Clr), .Enable(Enable), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdDataA(n_a), .RdAddrB(RdAddrB), .RdDataB(n_b),
    .SetBusy(SetBusy), .SetBusyAddr(SetBusyAddr), .BusyA(n_ba), .BusyB(n_bb));

  register_file #(.WIDTH(8), .DEPTH(3), .BYPASS(1), .R0_ZERO(1)) u_zero (
    .Clock(Clock), .Clr(Clr), .Enable(Enable), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdDataA(z_a), .RdAddrB(RdAddrB), .RdDataB(z_b),
    .SetBusy(SetBusy), .SetBusyAddr(SetBusyAddr), .BusyA(z_ba), .BusyB(z_bb));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Observation points selectable by the scoreboard entries.
  localparam int M_A = 0, M_B = 1, M_BA = 2, M_BB = 3, N_A = 4, N_BA = 5, Z_A = 6, Z_BA = 7, Z_B = 8;

  typedef struct {
    string      nm;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   req   = 0;
  int   served = 0;

  function automatic logic [7:0] observe(input int sel);
    logic [7:0] v;
    v = 8'hxx;
    case (sel)
      M_A:  v = m_a;
      M_B:  v = m_b;
      M_BA: v = {7'd0, m_ba};
      M_BB: v = {7'd0, m_bb};
      N_A:  v = n_a;
      N_BA: v = {7'd0, n_ba};
      Z_A:  v = z_a;
      Z_BA: v = {7'd0, z_ba};
      Z_B:  v = z_b;
      default: v = 8'hxx;
    endcase
    return v;
  endfunction

  task automatic expect_v(input string nm, input int sel, input logic [7:0] e);
    exp_t it;
    it.nm  = nm;
    it.sel = sel;
    it.exp = e;
    exp_q.push_back(it);
  endtask

  // Monitor: whenever a check is requested, pop every pending expectation and compare.
  initial begin
    exp_t it;
    logic [7:0] act;
    forever begin
      wait (served != req);
      while (exp_q.size() > 0) begin
        it  = exp_q.pop_front();
        act = observe(it.sel);
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: got %0h expected %0h at %0t", it.nm, act, it.exp, $time);
        end
      end
      served++;
    end
  end

  task automatic check_now();
    #1;
    req++;
    for (int i = 0; i < 50 && served != req; i++) #0.01;
    if (served != req) begin
      total++;
      bad++;
      $display("FAIL monitor_timeout: served %0d expected %0d", served, req);
      served = req;
      exp_q.delete();
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    WrEn    = 1'b0;
    SetBusy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Clr = 1'b1; Enable = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    RdAddrA = '0; RdAddrB = '0; SetBusy = 1'b0; SetBusyAddr = '0;
    step(); step();
    expect_v("reset_rda", M_A, 8'h00);
    expect_v("reset_busya", M_BA, 8'h00);
    check_now();
    Clr = 1'b0;

    // Basic write/read
    WrEn = 1'b1; WrAddr = 2'd1; WrData = 8'd7; step();
    WrAddr = 2'd2; WrData = 8'd8; step();
    idle(); RdAddrA = 2'd1; RdAddrB = 2'd2;
    expect_v("basic_a", M_A, 8'd7);
    expect_v("basic_b", M_B, 8'd8);
    expect_v("basic_nb_a", N_A, 8'd7);
    expect_v("basic_z_b", Z_B, 8'd8);
    check_now();

    // Enable gating
    Enable = 1'b0; WrEn = 1'b1; WrAddr = 2'd3; WrData = 8'h55; RdAddrA = 2'd3; step();
    idle();
    expect_v("gated_write", M_A, 8'h00);
    check_now();
    Enable = 1'b1; WrEn = 1'b1;
    expect_v("nobyp_old_value", N_A, 8'h00);
    check_now();
    step(); idle();
    expect_v("enabled_write", M_A, 8'h55);
    expect_v("enabled_nb", N_A, 8'h55);
    expect_v("z_oor_read", Z_A, 8'h00);
    check_now();

    // Bypass
    RdAddrA = 2'd2; WrAddr = 2'd2; WrData = 8'hA5; WrEn = 1'b1;
    expect_v("bypass_same_cycle", M_A, 8'hA5);
    expect_v("nobyp_same_cycle", N_A, 8'd8);
    check_now();
    step(); idle();
    expect_v("nobyp_after_edge", N_A, 8'hA5);
    check_now();

    // Scoreboard
    SetBusy = 1'b1; SetBusyAddr = 2'd1; RdAddrA = 2'd1; RdAddrB = 2'd1;
    expect_v("busy_before_edge", M_BA, 8'd0);
    check_now();
    step(); idle();
    expect_v("busy_set_a", M_BA, 8'd1);
    expect_v("busy_set_b", M_BB, 8'd1);
    expect_v("busy_set_nb", N_BA, 8'd1);
    expect_v("busy_set_z", Z_BA, 8'd1);
    check_now();
    WrEn = 1'b1; WrAddr = 2'd1; WrData = 8'h11;
    expect_v("busy_retire_byp", M_BA, 8'd0);
    expect_v("busy_retire_nb", N_BA, 8'd1);
    expect_v("retire_data_byp", M_A, 8'h11);
    expect_v("retire_data_nb", N_A, 8'd7);
    check_now();
    step(); idle();
    expect_v("busy_cleared", M_BA, 8'd0);
    expect_v("busy_cleared_nb", N_BA, 8'd0);
    check_now();
    SetBusy = 1'b1; SetBusyAddr = 2'd1; WrEn = 1'b1; WrAddr = 2'd1; WrData = 8'h22;
    step(); idle();
    expect_v("set_wins", M_BA, 8'd1);
    expect_v("set_wins_nb", N_BA, 8'd1);
    expect_v("set_wins_data", M_A, 8'h22);
    check_now();
    WrEn = 1'b1; WrAddr = 2'd1; WrData = 8'h23; step(); idle();
    expect_v("busy_retired", M_BA, 8'd0);
    check_now();

    // Hardwired zero entry and out-of-range accesses
    RdAddrA = 2'd0; RdAddrB = 2'd0;
    WrEn = 1'b1; WrAddr = 2'd0; WrData = 8'hFF; SetBusy = 1'b1; SetBusyAddr = 2'd0;
    expect_v("r0_no_bypass", Z_A, 8'h00);
    expect_v("r0_main_bypass", M_A, 8'hFF);
    check_now();
    step(); idle();
    expect_v("r0_write_dropped", Z_A, 8'h00);
    expect_v("r0_main_written", M_A, 8'hFF);
    expect_v("r0_nb_written", N_A, 8'hFF);
    expect_v("r0_busy_main", M_BA, 8'd1);
    expect_v("r0_busy_dropped", Z_BA, 8'd0);
    check_now();
    SetBusy = 1'b1; SetBusyAddr = 2'd3; RdAddrA = 2'd3; step(); idle();
    expect_v("oor_busy_main", M_BA, 8'd1);
    expect_v("oor_busy_z", Z_BA, 8'd0);
    expect_v("oor_read_z", Z_A, 8'h00);
    check_now();

    // Asynchronous reset mid-run
    for (int i = 0; i < 4; i++) begin
      WrEn = 1'b1; WrAddr = AW'(i); WrData = 8'd7; step();
    end
    idle();
    SetBusy = 1'b1; SetBusyAddr = 2'd3; RdAddrA = 2'd3; RdAddrB = 2'd2; step(); idle();
    expect_v("loaded_a", M_A, 8'd7);
    expect_v("loaded_b", M_B, 8'd7);
    expect_v("loaded_busy", M_BA, 8'd1);
    check_now();
    #2;
    Clr = 1'b1; WrEn = 1'b1; WrAddr = 2'd1; WrData = 8'h99;
    expect_v("clr_async_a", M_A, 8'h00);
    expect_v("clr_async_b", M_B, 8'h00);
    expect_v("clr_async_busy", M_BA, 8'd0);
    expect_v("clr_async_nb", N_A, 8'h00);
    check_now();
    step();
    Clr = 1'b0; idle(); RdAddrA = 2'd1;
    expect_v("clr_write_lost", M_A, 8'h00);
    expect_v("clr_write_lost_nb", N_A, 8'h00);
    check_now();
    WrEn = 1'b1; WrAddr = 2'd1; WrData = 8'h05; step(); idle();
    expect_v("post_clr_write", M_A, 8'h05);
    check_now();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
